// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_queue
// Description : In-order writeback queue between result producers and the
//               register-file write port. Accepts one result per cycle,
//               drains the head whenever the write port is free, and
//               optionally exposes pending writes to operand forwarding.
//
//               Ports
//                 clk, rst_n          clock, synchronous active-low reset
//                 in_valid/in_ready   producer handshake
//                 in_rd, in_data      destination index and result value
//                 wb_stall            write port busy; head is held
//                 WE, A3, WD          register-file write port
//                 q_rs1/q_rs2         forwarding query indices
//                 q_hit1/q_hit2       query has a pending queued write
//                 q_data1/q_data2     youngest pending value for that query
//                 count               current occupancy (0..DEPTH)
//
//               Build option
//                 WB_QUEUE_FWD_EN     when defined, forwarding compare
//                                     logic is built; otherwise the query
//                                     outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rd,
  input  logic [31:0]              in_data,
  input  logic                     wb_stall,
  output logic                     WE,
  output logic [4:0]               A3,
  output logic [31:0]              WD,
  input  logic [4:0]               q_rs1,
  input  logic [4:0]               q_rs2,
  output logic                     q_hit1,
  output logic                     q_hit2,
  output logic [31:0]              q_data1,
  output logic [31:0]              q_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry storage is never cleared; validity comes from pointers/count only.
  logic [4:0]    r_rd   [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_has_head;
  logic w_push;

  // Outputs are forced quiet while reset is asserted, even before the
  // reset edge has cleared the occupancy.
  assign w_has_head = rst_n && (r_count != '0);

  // Depends only on stored occupancy: a full queue refuses a push even in a
  // cycle where the head is being written.
  assign in_ready   = (r_count < CW'(DEPTH));

  // Writes to x0 complete the handshake but are never stored.
  assign w_push     = in_valid && in_ready && (in_rd != 5'd0);

  assign WE    = w_has_head && !wb_stall;
  assign A3    = w_has_head ? r_rd[r_rptr]   : 5'd0;
  assign WD    = w_has_head ? r_data[r_rptr] : 32'd0;
  assign count = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (WE) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, WE})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_rd[r_wptr]   <= in_rd;
      r_data[r_wptr] <= in_data;
    end
  end

`ifdef WB_QUEUE_FWD_EN
  // Scan from oldest to youngest so a later match overwrites an earlier one,
  // leaving the most recently pushed value. The head entry is included until
  // it is actually popped; the same-cycle input is not considered.
  function automatic logic [32:0] f_lookup(input logic [4:0] rs);
    logic          hit;
    logic [31:0]   data;
    logic [AW-1:0] idx;
    hit  = 1'b0;
    data = 32'd0;
    idx  = '0;
    if (rst_n && (rs != 5'd0)) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = r_rptr + AW'(i);
        if ((CW'(i) < r_count) && (r_rd[idx] == rs)) begin
          hit  = 1'b1;
          data = r_data[idx];
        end
      end
    end
    return {hit, data};
  endfunction

  assign {q_hit1, q_data1} = f_lookup(q_rs1);
  assign {q_hit2, q_data2} = f_lookup(q_rs2);
`else
  logic w_unused_q;
  assign w_unused_q = ^{q_rs1, q_rs2};

  assign q_hit1  = 1'b0;
  assign q_hit2  = 1'b0;
  assign q_data1 = 32'd0;
  assign q_data2 = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_queue
// Description : Directed self-checking bench for wb_queue (DEPTH = 4).
//               Query outputs are expected to follow the forwarding model
//               when WB_QUEUE_FWD_EN is defined and to stay zero otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        wb_stall;
  logic        WE;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        q_hit1;
  logic        q_hit2;
  logic [31:0] q_data1;
  logic [31:0] q_data2;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rd    (in_rd),
    .in_data  (in_data),
    .wb_stall (wb_stall),
    .WE       (WE),
    .A3       (A3),
    .WD       (WD),
    .q_rs1    (q_rs1),
    .q_rs2    (q_rs2),
    .q_hit1   (q_hit1),
    .q_hit2   (q_hit2),
    .q_data1  (q_data1),
    .q_data2  (q_data2),
    .count    (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (WE !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b expected 0", WE); end
    checks++; if (A3 !== 5'd0 || WD !== 32'd0) begin errors++; $display("FAIL reset_a3_wd: got %0h/%0h expected 0/0", A3, WD); end
    checks++; if (q_hit1 !== 1'b0 || q_data1 !== 32'd0) begin errors++; $display("FAIL reset_q1: got %0b/%0h expected 0/0", q_hit1, q_data1); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", in_ready); end
  endtask

  task automatic test_single();
    wb_stall = 1'b0;
    in_valid = 1'b1; in_rd = 5'd5; in_data = 32'h11;
    #1;
    checks++; if (WE !== 1'b0) begin errors++; $display("FAIL single_no_passthru: got %0b expected 0", WE); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (WE !== 1'b1 || A3 !== 5'd5 || WD !== 32'h11) begin errors++; $display("FAIL single_out: got %0b/%0d/%0h expected 1/5/11", WE, A3, WD); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count1: got %0d expected 1", count); end
    tick();
    checks++; if (count !== 3'd0 || WE !== 1'b0) begin errors++; $display("FAIL single_drained: got %0d/%0b expected 0/0", count, WE); end
  endtask

  task automatic test_full();
    wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_rd = 5'(i); in_data = 32'h100 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL full_state: got %0d/%0b expected 4/0", count, in_ready); end
    checks++; if (WE !== 1'b0 || A3 !== 5'd1) begin errors++; $display("FAIL full_stalled_head: got %0b/%0d expected 0/1", WE, A3); end
    in_valid = 1'b1; in_rd = 5'd9; in_data = 32'hDEAD;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_refuse: got %0d expected 4", count); end
    wb_stall = 1'b0;
    #1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (WE !== 1'b1 || A3 !== 5'(i) || WD !== 32'h100 + 32'(i)) begin
        errors++; $display("FAIL full_drain_%0d: got %0b/%0d/%0h expected 1/%0d/%0h", i, WE, A3, WD, i, 32'h100 + 32'(i));
      end
      tick();
    end
    checks++; if (count !== 3'd0 || WE !== 1'b0) begin errors++; $display("FAIL full_empty: got %0d/%0b expected 0/0", count, WE); end
  endtask

  task automatic test_forward();
    wb_stall = 1'b1;
    in_valid = 1'b1; in_rd = 5'd7; in_data = 32'hA;
    tick();
    in_rd = 5'd7; in_data = 32'hB;
    tick();
    in_valid = 1'b0;
    q_rs1 = 5'd7; q_rs2 = 5'd0;
    #1;
`ifdef WB_QUEUE_FWD_EN
    checks++; if (q_hit1 !== 1'b1 || q_data1 !== 32'hB) begin errors++; $display("FAIL fwd_youngest: got %0b/%0h expected 1/b", q_hit1, q_data1); end
`else
    checks++; if (q_hit1 !== 1'b0 || q_data1 !== 32'h0) begin errors++; $display("FAIL fwd_tied: got %0b/%0h expected 0/0", q_hit1, q_data1); end
`endif
    checks++; if (q_hit2 !== 1'b0 || q_data2 !== 32'h0) begin errors++; $display("FAIL fwd_x0: got %0b/%0h expected 0/0", q_hit2, q_data2); end
    // A result presented this cycle is not yet visible to queries.
    in_valid = 1'b1; in_rd = 5'd3; in_data = 32'h33; q_rs2 = 5'd3;
    #1;
    checks++; if (q_hit2 !== 1'b0 || q_data2 !== 32'h0) begin errors++; $display("FAIL fwd_same_cycle: got %0b/%0h expected 0/0", q_hit2, q_data2); end
    in_valid = 1'b0;
    // Pop the older rd=7; the remaining younger one must still be found.
    wb_stall = 1'b0;
    tick();
    wb_stall = 1'b1;
    #1;
`ifdef WB_QUEUE_FWD_EN
    checks++; if (q_hit1 !== 1'b1 || q_data1 !== 32'hB) begin errors++; $display("FAIL fwd_head_pending: got %0b/%0h expected 1/b", q_hit1, q_data1); end
`else
    checks++; if (q_hit1 !== 1'b0) begin errors++; $display("FAIL fwd_tied_after_pop: got %0b expected 0", q_hit1); end
`endif
    checks++; if (count !== 3'd1 || A3 !== 5'd7 || WD !== 32'hB) begin errors++; $display("FAIL fwd_after_pop: got %0d/%0d/%0h expected 1/7/b", count, A3, WD); end
    wb_stall = 1'b0;
    tick();
    q_rs1 = 5'd0; q_rs2 = 5'd0;
    #1;
    checks++; if (count !== 3'd0 || q_hit1 !== 1'b0) begin errors++; $display("FAIL fwd_drained: got %0d/%0b expected 0/0", count, q_hit1); end
  endtask

  task automatic test_rd_zero();
    wb_stall = 1'b0;
    in_valid = 1'b1; in_rd = 5'd0; in_data = 32'hFFFF_FFFF;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready: got %0b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd0 || WE !== 1'b0) begin errors++; $display("FAIL rd0_discard: got %0d/%0b expected 0/0", count, WE); end
    tick();
    checks++; if (WE !== 1'b0) begin errors++; $display("FAIL rd0_no_we: got %0b expected 0", WE); end
  endtask

  task automatic test_reset_mid();
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_rd = 5'(10 + i); in_data = 32'h50 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    q_rs1 = 5'd10;
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_count3: got %0d expected 3", count); end
`ifdef WB_QUEUE_FWD_EN
    checks++; if (q_hit1 !== 1'b1 || q_data1 !== 32'h50) begin errors++; $display("FAIL mid_fwd: got %0b/%0h expected 1/50", q_hit1, q_data1); end
`endif
    wb_stall = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (WE !== 1'b0 || q_hit1 !== 1'b0) begin errors++; $display("FAIL mid_during_rst: got %0b/%0b expected 0/0", WE, q_hit1); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (count !== 3'd0 || WE !== 1'b0 || q_hit1 !== 1'b0) begin errors++; $display("FAIL mid_after_rst: got %0d/%0b/%0b expected 0/0/0", count, WE, q_hit1); end
    q_rs1 = 5'd0;
    in_valid = 1'b1; in_rd = 5'd13; in_data = 32'h13;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (WE !== 1'b1 || A3 !== 5'd13 || WD !== 32'h13 || count !== 3'd1) begin errors++; $display("FAIL mid_next_push: got %0b/%0d/%0h/%0d expected 1/13/13/1", WE, A3, WD, count); end
    tick();
    checks++; if (count !== 3'd0 || WE !== 1'b0) begin errors++; $display("FAIL mid_alone: got %0d/%0b expected 0/0", count, WE); end
  endtask

  task automatic test_back_to_back();
    wb_stall = 1'b0;
    in_valid = 1'b1; in_rd = 5'd1; in_data = 32'h1000;
    tick();
    for (int j = 1; j < 20; j++) begin
      in_rd = 5'((j % 31) + 1); in_data = 32'h1000 + 32'(j);
      #1;
      checks++;
      if (WE !== 1'b1 || A3 !== 5'(((j - 1) % 31) + 1) || WD !== 32'h1000 + 32'(j - 1) || count !== 3'd1) begin
        errors++; $display("FAIL stream_%0d: got %0b/%0d/%0h/%0d expected 1/%0d/%0h/1", j, WE, A3, WD, count, ((j - 1) % 31) + 1, 32'h1000 + 32'(j - 1));
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (WE !== 1'b1 || A3 !== 5'd20 || WD !== 32'h1013) begin errors++; $display("FAIL stream_last: got %0b/%0d/%0h expected 1/20/1013", WE, A3, WD); end
    tick();
    checks++; if (count !== 3'd0 || WE !== 1'b0) begin errors++; $display("FAIL stream_empty: got %0d/%0b expected 0/0", count, WE); end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_rd    = 5'd0;
    in_data  = 32'd0;
    wb_stall = 1'b0;
    q_rs1    = 5'd0;
    q_rs2    = 5'd0;
    #2;
    test_reset();
    test_single();
    test_full();
    test_forward();
    test_rd_zero();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  producer offers a writeback result.
REQ-005 in_ready  output  1  queue can accept this cycle.
REQ-006 in_rd  input  5  destination register index.
REQ-007 in_data  input  32  result value.
REQ-008 wb_stall  input  1  register-file write port unavailable; hold head.
REQ-009 WE  output  1  register-file write enable.
REQ-010 A3  output  5  register-file write address.
REQ-011 WD  output  32  register-file write data.
REQ-012 q_rs1, q_rs2  input  5 each  forwarding query indices.
REQ-013 q_hit1, q_hit2  output  1 each  queried register has a pending queued write.
REQ-014 q_data1, q_data2  output  32 each  youngest pending value for the queried register.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 Queue is in-order FIFO; push when in_valid && in_ready at the rising edge.
REQ-017 in_ready = (count < DEPTH); no combinational dependence on wb_stall or pop, so full queue refuses push even when popping that cycle.
REQ-018 Push with in_rd == 0: handshake completes, entry discarded, count unchanged.
REQ-019 WE = (count != 0) && !wb_stall; A3/WD = head entry rd/data when count != 0, else 0.
REQ-020 Pop occurs at the rising edge where WE = 1; head advances one entry.
REQ-021 Latency: entry pushed at edge N is earliest on WE/A3/WD during cycle N+1 (no empty pass-through).
REQ-022 Simultaneous push and pop (count between 1 and DEPTH-1): count unchanged, both take effect.
REQ-023 Read/write pointers wrap modulo DEPTH; count tracks 0..DEPTH exactly, never over/underflows.
REQ-024 wb_stall held for any length: head, count, and all entries unchanged except pushes.
REQ-025 Forwarding: q_hitN = 1 iff some valid entry has rd == q_rsN and q_rsN != 0; combinational.
REQ-026 Multiple matches: q_dataN = data of youngest (most recently pushed) match; no match -> q_dataN = 0.
REQ-027 The entry currently on WE/A3/WD still counts as pending for forwarding until popped.
REQ-028 Same-cycle in_data is not forwarded; only entries already stored.

Reset
REQ-029 rst_n = 0 at a rising edge: count = 0, pointers = 0; queued entries discarded, including mid-drain.
REQ-030 During and after reset: WE = 0, A3 = 0, WD = 0, q_hit1/2 = 0, q_data1/2 = 0, in_ready = 1 once rst_n = 1.
REQ-031 Entry storage contents are not cleared; valid state derives only from pointers/count.

Configuration
REQ-032 Macro WB_QUEUE_FWD_EN defined: forwarding logic per REQ-025..REQ-028 present.
REQ-033 Macro WB_QUEUE_FWD_EN undefined: no compare logic; q_hit1/2 tied 0, q_data1/2 tied 0; all other behaviour identical.

Verification
REQ-034 Push (rd=5, 0x11) at edge 1, wb_stall=0 -> cycle 2: WE=1, A3=5, WD=0x11; count 0 after edge 2.
REQ-035 4 pushes rd=1..4 with wb_stall=1 -> count=4, in_ready=0; 5th in_valid not accepted; release stall -> rd 1,2,3,4 written on 4 consecutive cycles in order.
REQ-036 Push rd=7 0xA then rd=7 0xB, stall=1, query q_rs1=7 -> q_hit1=1, q_data1=0xB; q_rs2=0 -> q_hit2=0.
REQ-037 Push rd=0 data 0xFFFF_FFFF -> handshake completes, count stays 0, WE never asserts.
REQ-038 Queue holds 3 entries, rst_n=0 one edge -> count=0, WE=0, q_hit=0; next push appears alone at output.
REQ-039 Streaming 20 pushes, push+pop every cycle at count=1 -> count stays 1, pointer wrap correct, all 20 written in order.
